// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU unit.
// Used by div_unit_if and div_unit.
package div_unit_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef logic [2*DATA_W-1:0] double_reg_bus_t;

    // Magnitude of a two's-complement operand; raw value in unsigned mode.
    function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v,
                                                 input logic               is_signed);
        return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider handshake bundle. The div_zero signal exists only when
// DIV_ZERO_FLAG_EN is defined.
interface div_unit_if import div_unit_pkg::*; ();

    logic                  signed_div;
    logic [DATA_W-1:0]     opdata1;
    logic [DATA_W-1:0]     opdata2;
    logic                  start;
    logic                  annul;
    double_reg_bus_t       result;
    logic                  ready;
`ifdef DIV_ZERO_FLAG_EN
    logic                  div_zero;
`endif

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
`ifdef DIV_ZERO_FLAG_EN
        input  div_zero,
`endif
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
`ifdef DIV_ZERO_FLAG_EN
        output div_zero,
`endif
        output result, ready
    );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider beside EX; result = {remainder, quotient} -> {HI, LO}.
// Optional div_zero flag when DIV_ZERO_FLAG_EN is defined.
//
// state  | meaning
// FREE   | idle, waiting for start
// BYZERO | divisor was zero, short path to END
// ON     | iterating, one quotient bit per cycle
// END    | result valid, held until start drops
module div_unit import div_unit_pkg::*; (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave div_bus
);

    div_state_e        state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*DATA_W:0] work_q;
    logic [DATA_W-1:0] divisor_q;
    logic              neg_quot_q, neg_rem_q;
    double_reg_bus_t   result_q, result_nxt;
    logic              ready_q, ready_nxt;

    logic [DATA_W-1:0] dividend_abs, divisor_abs;
    logic [DATA_W-1:0] quot_fix, rem_fix;
    logic [DATA_W:0]   diff;
    logic              cnt_done, take_start;

    assign dividend_abs = abs_op(div_bus.opdata1, div_bus.signed_div);
    assign divisor_abs  = abs_op(div_bus.opdata2, div_bus.signed_div);
    assign take_start   = (div_bus.start == DIV_START) && !div_bus.annul;
    assign cnt_done     = (cnt_q == CNT_W'(DATA_W));

    assign diff = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};

    assign quot_fix = neg_quot_q ? (~work_q[DATA_W-1:0] + 1'b1)
                                 : work_q[DATA_W-1:0];
    assign rem_fix  = neg_rem_q  ? (~work_q[2*DATA_W:DATA_W+1] + 1'b1)
                                 : work_q[2*DATA_W:DATA_W+1];

    // State, counter and working register share one clocked process.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q  <= state_nxt;
            result_q <= result_nxt;
            ready_q  <= ready_nxt;
            case (state_q)
                DIV_FREE: begin
                    if (take_start) begin
                        cnt_q      <= '0;
                        work_q     <= {{DATA_W{1'b0}}, dividend_abs, 1'b0};
                        divisor_q  <= divisor_abs;
                        neg_quot_q <= div_bus.signed_div &
                                      (div_bus.opdata1[DATA_W-1] ^ div_bus.opdata2[DATA_W-1]);
                        neg_rem_q  <= div_bus.signed_div & div_bus.opdata1[DATA_W-1];
                    end
                end
                DIV_ON: begin
                    if (!div_bus.annul && !cnt_done) begin
                        if (diff[DATA_W])
                            work_q <= {work_q[2*DATA_W-1:0], 1'b0};
                        else
                            work_q <= {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            DIV_FREE: begin
                if (take_start)
                    state_nxt = (div_bus.opdata2 == '0) ? DIV_BYZERO : DIV_ON;
            end
            DIV_BYZERO: state_nxt = DIV_END;
            DIV_ON: begin
                if (div_bus.annul)
                    state_nxt = DIV_FREE;
                else if (cnt_done)
                    state_nxt = DIV_END;
            end
            DIV_END: begin
                if (div_bus.start == DIV_STOP)
                    state_nxt = DIV_FREE;
            end
            default: state_nxt = DIV_FREE;
        endcase
    end

    always_comb begin
        result_nxt = result_q;
        ready_nxt  = ready_q;
        case (state_q)
            DIV_FREE: begin
                result_nxt = '0;
                ready_nxt  = DIV_RESULT_NOT_READY;
            end
            DIV_BYZERO: begin
                result_nxt = '0;
                ready_nxt  = DIV_RESULT_READY;
            end
            DIV_ON: begin
                if (!div_bus.annul && cnt_done) begin
                    result_nxt = {rem_fix, quot_fix};
                    ready_nxt  = DIV_RESULT_READY;
                end else begin
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                end
            end
            DIV_END: begin
                if (div_bus.start == DIV_STOP) begin
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                result_nxt = '0;
                ready_nxt  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    assign div_bus.result = result_q;
    assign div_bus.ready  = ready_q;

`ifdef DIV_ZERO_FLAG_EN
    logic div_zero_q, div_zero_nxt;

    // Raised entering BYZERO, kept through END, dropped whenever FREE is re-entered.
    always_comb begin
        div_zero_nxt = div_zero_q;
        if (state_nxt == DIV_BYZERO)
            div_zero_nxt = 1'b1;
        else if (state_nxt == DIV_FREE)
            div_zero_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            div_zero_q <= 1'b0;
        else
            div_zero_q <= div_zero_nxt;
    end

    assign div_bus.div_zero = div_zero_q;
`endif

endmodule
